move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The module SHALL have parameter buffer_bits, default 2, meaning the width of the move-slot index.
REQ-002 The module SHALL have parameter buffer_size, default 2, meaning the number of move slots, with buffer_size <= 2**buffer_bits.
REQ-003 The module SHALL have parameter move_duration_bits, default 32, meaning the width of a move duration in DDA ticks.
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 The module SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port dda_tick, input, 1 bit: one-CLK strobe marking a DDA timestep.
REQ-007 The module SHALL have port stepready, input, buffer_size bits: per-slot toggle; a change marks that slot loaded by the SPI side.
REQ-008 The module SHALL have port move_duration, input, move_duration_bits: duration of slot moveind, driven by the caller.
REQ-009 The module SHALL have port halt, input, 1 bit: synchronous pause request.
REQ-010 The module SHALL have port moveind, output, buffer_bits: index of the slot being or next to be executed.
REQ-011 The module SHALL have port loading_move, output, 1 bit: one-CLK pulse telling the per-axis timers to latch slot parameters.
REQ-012 The module SHALL have port executing_move, output, 1 bit: timers advance on dda_tick while high.
REQ-013 The module SHALL have port move_done, output, 1 bit: one-CLK pulse at move completion.
REQ-014 The module SHALL have port buffer_dtr, output, 1 bit: at least one slot is free for writing.

Function
REQ-015 The module SHALL keep an internal finished[buffer_size] toggle vector; slot i is pending iff stepready[i] != finished[i].
REQ-016 The module SHALL implement the states IDLE, LOAD, RUN and FINISH.
REQ-017 In IDLE, when slot moveind is pending and halt=0, the module SHALL go to LOAD on the next edge; otherwise it SHALL stay in IDLE.
REQ-018 In LOAD, the module SHALL drive loading_move=1 for exactly one cycle and capture move_duration into the down-counter.
REQ-019 On leaving LOAD, the module SHALL go to FINISH if the captured duration is 0, else to RUN.
REQ-020 In RUN, the module SHALL drive executing_move=1 when halt=0 and executing_move=0 when halt=1.
REQ-021 In RUN with halt=0, each dda_tick SHALL decrement the counter by 1.
REQ-022 In RUN, the dda_tick taken with counter==1 SHALL move the state to FINISH, so that exactly duration ticks are executed.
REQ-023 In RUN with halt=1, the module SHALL freeze the counter and ignore dda_tick.
REQ-024 In FINISH, the module SHALL, for exactly one cycle, pulse move_done, toggle finished[moveind], advance moveind (buffer_size-1 wraps to 0), and then return to IDLE.
REQ-025 The module SHALL ignore dda_tick in IDLE, LOAD and FINISH.
REQ-026 A stepready toggle on the next slot coincident with FINISH SHALL be detected in the following IDLE cycle and SHALL NOT be lost.
REQ-027 The module SHALL register buffer_dtr as 1 iff any slot is not pending; it SHALL be 0 when all buffer_size slots are pending, including the executing slot.
REQ-028 A stepready toggle on an already pending slot is a protocol violation; the module has no required behaviour for it.
REQ-029 The counter SHALL be move_duration_bits wide and SHALL never underflow.

Reset
REQ-030 While resetn=0 at a CLK edge, the module SHALL force state=IDLE, moveind=0, finished=0, counter=0, loading_move=0, executing_move=0, move_done=0 and buffer_dtr=1.
REQ-031 Reset mid-move SHALL abandon the move with no move_done pulse; the SPI side resets stepready to 0 in the same reset.

Structure
REQ-032 The state encodings SHALL live in the shared include with the existing MOVE_BUFFER_BITS/MOVE_BUFFER_SIZE macros.
REQ-033 The implementation SHALL be a single flat module with no sub-module; the parent instantiates it in place of the current DDA FSM with identical port names.

Verification
REQ-034 Toggle stepready[0] with duration=3 and dda_tick every 4 CLK -> loading_move for 1 cycle, executing_move spanning exactly 3 ticks, one move_done, moveind 0->1.
REQ-035 Load duration=0 -> loading_move pulse, executing_move never high, move_done 2 cycles after LOAD, moveind advances.
REQ-036 Toggle stepready[0] and stepready[1] back-to-back with durations 2 and 2 -> buffer_dtr=0 until the first move_done, then 1; the second move starts without a new toggle; moveind wraps 1->0.
REQ-037 Duration=5; hold halt for 10 ticks after 2 ticks -> executing_move=0 and counter frozen during the halt; exactly 5 ticks total, then move_done.
REQ-038 Assert resetn=0 mid-RUN -> all outputs at reset values the next cycle, no move_done; a fresh toggle afterwards executes normally.
REQ-039 Assert dda_tick in the same cycle as LOAD, and separately in FINISH -> the tick is not counted, and executed tick count equals duration.

Source files
------------

// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the move sequencer: slot-buffer geometry and the
// sequencer state encoding used by the DDA move controller.
package move_sequencer_pkg;

  localparam int MOVE_BUFFER_BITS = 2;
  localparam int MOVE_BUFFER_SIZE = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/move_sequencer.sv
// Move sequencer: walks the move-slot ring buffer, loads each pending slot into
// the per-axis timers, runs it for exactly move_duration DDA ticks (pausable by
// halt) and then releases the slot back to the SPI side.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int buffer_bits        = MOVE_BUFFER_BITS,
  parameter int buffer_size        = MOVE_BUFFER_SIZE,
  parameter int move_duration_bits = 32
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic                          dda_tick,
  input  logic [buffer_size-1:0]        stepready,
  input  logic [move_duration_bits-1:0] move_duration,
  input  logic                          halt,
  output logic [buffer_bits-1:0]        moveind,
  output logic                          loading_move,
  output logic                          executing_move,
  output logic                          move_done,
  output logic                          buffer_dtr
);

  seq_state_t                    state;
  logic [buffer_size-1:0]        finished;
  logic [buffer_size-1:0]        finished_nxt;
  logic [buffer_size-1:0]        pending;
  logic [buffer_size-1:0]        slot_sel;
  logic                          slot_pending;
  logic [move_duration_bits-1:0] ticks_left;

  // Ring-buffer successor of a slot index; the last populated slot wraps to 0.
  function automatic logic [buffer_bits-1:0] next_slot(input logic [buffer_bits-1:0] idx);
    if (idx == buffer_bits'(buffer_size - 1))
      return '0;
    return idx + buffer_bits'(1);
  endfunction

  // Decode the current slot and work out which slots the SPI side has filled
  // but the sequencer has not yet consumed.
  always_comb begin
    slot_sel = '0;
    for (int i = 0; i < buffer_size; i++) begin
      if (moveind == buffer_bits'(i))
        slot_sel[i] = 1'b1;
    end
    pending      = stepready ^ finished;
    slot_pending = |(pending & slot_sel);
    // The slot is released on the edge leaving FINISH, so buffer_dtr is
    // computed from the post-edge finished vector to rise together with move_done.
    finished_nxt = (state == ST_FINISH) ? (finished ^ slot_sel) : finished;
  end

  // Timers must stop in the very cycle halt rises, so this follows halt directly.
  assign executing_move = (state == ST_RUN) && !halt;

  // Sequencer FSM with registered strobes and the move duration down-counter.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      moveind      <= '0;
      finished     <= '0;
      ticks_left   <= '0;
      loading_move <= 1'b0;
      move_done    <= 1'b0;
      buffer_dtr   <= 1'b1;
    end else begin
      loading_move <= 1'b0;
      move_done    <= 1'b0;
      finished     <= finished_nxt;
      buffer_dtr   <= ~&(stepready ^ finished_nxt);
      case (state)
        ST_IDLE: begin
          if (slot_pending && !halt) begin
            state        <= ST_LOAD;
            loading_move <= 1'b1;
          end
        end
        ST_LOAD: begin
          ticks_left <= move_duration;
          state      <= (move_duration == '0) ? ST_FINISH : ST_RUN;
        end
        ST_RUN: begin
          if (!halt && dda_tick) begin
            // The tick consumed at a count of one is the last one of the move;
            // the guard on zero keeps the counter from ever wrapping.
            if (ticks_left <= move_duration_bits'(1)) begin
              ticks_left <= '0;
              state      <= ST_FINISH;
            end else begin
              ticks_left <= ticks_left - move_duration_bits'(1);
            end
          end
        end
        ST_FINISH: begin
          move_done <= 1'b1;
          moveind   <= next_slot(moveind);
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: moves are queued as they are written into
// slots, and a monitor retires them on move_done, checking slot order, executed
// tick count, duration-0 latency, halt behaviour and buffer_dtr.
module tb_move_sequencer;

  localparam int BB = 2;
  localparam int BS = 2;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic          dda_tick = 1'b0;
  logic          halt = 1'b0;
  logic [BS-1:0] stepready = '0;
  logic [DW-1:0] move_duration;
  logic [BB-1:0] moveind;
  logic          loading_move;
  logic          executing_move;
  logic          move_done;
  logic          buffer_dtr;

  logic [DW-1:0] dur_mem [4];
  assign move_duration = dur_mem[moveind];

  typedef struct {
    int slot;
    int dur;
  } exp_t;
  exp_t sq[$];

  int total;
  int bad;
  int snap;
  int mon_en;
  int in_move;
  int tick_cnt;
  int exec_cyc;
  int cyc_cnt;
  int wr_ptr;
  int tick_period;
  int halt_mode;

  move_sequencer #(
    .buffer_bits(BB),
    .buffer_size(BS),
    .move_duration_bits(DW)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .dda_tick(dda_tick),
    .stepready(stepready),
    .move_duration(move_duration),
    .halt(halt),
    .moveind(moveind),
    .loading_move(loading_move),
    .executing_move(executing_move),
    .move_done(move_done),
    .buffer_dtr(buffer_dtr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Tick generator: fixed period, or random when tick_period is 0.
  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge CLK); #1;
      if (tick_period == 0) dda_tick = ($urandom_range(0, 1) == 1);
      else begin
        ph = (ph + 1) % tick_period;
        dda_tick = (ph == 0);
      end
    end
  end

  // Halt generator: off, random bursts, or left to the main sequence.
  initial begin : halt_gen
    forever begin
      @(posedge CLK); #1;
      if (halt_mode == 0) halt = 1'b0;
      else if (halt_mode == 1 && $urandom_range(0, 7) == 0) halt = ~halt;
    end
  end

  // Outstanding moves as seen by the DUT at each edge.
  always @(posedge CLK) snap = sq.size();

  // Monitor: retires queued moves and checks per-cycle invariants.
  always @(negedge CLK) begin
    if (mon_en == 0) begin
      in_move  = 0;
      tick_cnt = 0;
      exec_cyc = 0;
      cyc_cnt  = 0;
    end else begin
      check("buffer_dtr", buffer_dtr, ((snap - (move_done ? 1 : 0)) < BS) ? 1 : 0);
      if (executing_move) begin
        check("exec_inside_move", in_move, 1);
        check("exec_while_halt", halt, 0);
        exec_cyc++;
        if (dda_tick) tick_cnt++;
      end
      if (loading_move) begin
        check("load_while_busy", in_move, 0);
        if (sq.size() == 0) fail_now("load_unexpected");
        else check("load_slot", moveind, sq[0].slot);
        in_move  = 1;
        tick_cnt = 0;
        exec_cyc = 0;
        cyc_cnt  = 0;
      end else if (in_move != 0) begin
        cyc_cnt++;
      end
      if (move_done) begin
        if (sq.size() == 0) fail_now("done_unexpected");
        else begin
          exp_t e;
          e = sq.pop_front();
          check("done_after_load", in_move, 1);
          check("ticks_executed", tick_cnt, e.dur);
          check("moveind_next", moveind, (e.slot + 1) % BS);
          if (e.dur == 0) begin
            check("zero_dur_latency", cyc_cnt, 2);
            check("zero_dur_exec_cycles", exec_cyc, 0);
          end
        end
        in_move = 0;
      end
    end
  end

  task automatic issue(input int d);
    int guard;
    guard = 0;
    @(posedge CLK); #1;
    while (sq.size() >= BS && guard < 3000) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 3000) begin
      fail_now("issue_wait_timeout");
      return;
    end
    dur_mem[wr_ptr] = DW'(d);
    stepready = stepready ^ BS'(1 << wr_ptr);
    sq.push_back('{slot: wr_ptr, dur: d});
    wr_ptr = (wr_ptr + 1) % BS;
  endtask

  task automatic wait_idle(input int limit);
    int guard;
    guard = 0;
    while (sq.size() != 0 && guard < limit) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (sq.size() != 0) begin
      fail_now("drain_timeout");
      sq.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_moveind"}, moveind, 0);
    check({tag, "_loading"}, loading_move, 0);
    check({tag, "_executing"}, executing_move, 0);
    check({tag, "_done"}, move_done, 0);
    check({tag, "_dtr"}, buffer_dtr, 1);
  endtask

  initial begin
    int guard;
    total = 0; bad = 0; snap = 0; mon_en = 0; in_move = 0;
    wr_ptr = 0; tick_period = 4; halt_mode = 0;
    for (int i = 0; i < 4; i++) dur_mem[i] = '0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1;
    resetn = 1'b1;
    mon_en = 1;

    // Single move, three ticks at one tick per four clocks.
    tick_period = 4;
    issue(3);
    wait_idle(300);

    // Zero-length move.
    issue(0);
    wait_idle(100);

    // Two slots filled back to back; second starts without a new toggle.
    tick_period = 3;
    issue(2);
    issue(2);
    wait_idle(300);

    // Halt held well past two ticks into a five-tick move.
    tick_period = 2;
    halt_mode = 2;
    issue(5);
    guard = 0;
    while (tick_cnt < 2 && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 200) fail_now("halt_setup_timeout");
    halt = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    halt = 1'b0;
    halt_mode = 0;
    wait_idle(300);

    // Tick on every clock, so ticks land in LOAD and FINISH too.
    tick_period = 1;
    issue(4);
    issue(0);
    issue(1);
    wait_idle(300);

    // Reset in the middle of a running move.
    issue(30);
    guard = 0;
    while (tick_cnt < 3 && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 200) fail_now("midrun_setup_timeout");
    resetn = 1'b0;
    stepready = '0;
    mon_en = 0;
    sq.delete();
    wr_ptr = 0;
    @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("midrun_reset");
    @(posedge CLK); #1;
    resetn = 1'b1;
    mon_en = 1;
    tick_period = 4;
    issue(3);
    wait_idle(300);

    // Randomised moves with random ticks and halt bursts.
    tick_period = 0;
    halt_mode = 1;
    for (int n = 0; n < 40; n++) begin
      issue(int'($urandom_range(0, 6)));
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
    wait_idle(5000);
    halt_mode = 0;
    repeat (3) @(posedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
